// File: rtl/inst_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit_if
// Instruction-memory request/response bus between the fetch unit and memory.
// Revision: 1.0
// ============================================================================
interface inst_fetch_unit_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// inst_fetch_unit
// Single-outstanding-request fetch stage feeding the IF/ID register.
// Revision: 1.0
// ============================================================================
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  wire logic               clk,
   input  wire logic               reset,
   input  wire logic               stall,
   input  wire logic               redirect,
   input  wire logic [31:0]        redirect_pc,
   inst_fetch_unit_if.master       imem,
   output      logic [31:0]        pc_out,
   output      logic [31:0]        instruction_out,
   output      logic               valid_out
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_pc_q, w_pc_q_next;
   logic [31:0] r_req_pc, w_req_pc_next;
   logic [31:0] r_skid, w_skid_next;
   logic        r_kill, w_kill_next;
   logic [31:0] w_pc_out_next, w_instr_next;
   logic        w_valid_next;
   logic        w_slot_free;
   logic [31:0] w_redirect_pc;

   assign w_slot_free   = !valid_out || !stall;
   assign w_redirect_pc = redirect_pc & ~32'h3;

   assign imem.imem_req  = (r_state == S_REQ);
   assign imem.imem_addr = r_pc_q;

   always_comb begin
      w_state_next  = r_state;
      w_pc_q_next   = r_pc_q;
      w_req_pc_next = r_req_pc;
      w_skid_next   = r_skid;
      w_kill_next   = r_kill;
      w_pc_out_next = pc_out;
      w_instr_next  = instruction_out;
      w_valid_next  = valid_out;

      // IF/ID takes the presented word this cycle; empty the slot unless refilled below
      if (valid_out && !stall) begin
         w_valid_next = 1'b0;
         w_instr_next = NOP_INSTR;
      end

      case (r_state)
         S_IDLE: begin
            w_state_next = S_REQ;
         end

         S_REQ: begin
            if (redirect) begin
               w_pc_q_next  = w_redirect_pc;
               w_valid_next = 1'b0;
               w_instr_next = NOP_INSTR;
               if (imem.imem_ready) begin
                  w_kill_next  = 1'b1;
                  w_state_next = S_WAIT;
               end
            end else if (imem.imem_ready) begin
               w_req_pc_next = r_pc_q;
               w_pc_q_next   = r_pc_q + 32'd4;
               w_state_next  = S_WAIT;
            end
         end

         S_WAIT: begin
            if (redirect) begin
               w_pc_q_next  = w_redirect_pc;
               w_valid_next = 1'b0;
               w_instr_next = NOP_INSTR;
               if (imem.imem_rvalid) begin
                  w_kill_next  = 1'b0;
                  w_state_next = S_REQ;
               end else begin
                  w_kill_next  = 1'b1;
               end
            end else if (imem.imem_rvalid) begin
               if (r_kill) begin
                  w_kill_next  = 1'b0;
                  w_state_next = S_REQ;
               end else if (w_slot_free) begin
                  w_pc_out_next = r_req_pc;
                  w_instr_next  = imem.imem_rdata;
                  w_valid_next  = 1'b1;
                  w_state_next  = S_REQ;
               end else begin
                  w_skid_next  = imem.imem_rdata;
                  w_state_next = S_HOLD;
               end
            end
         end

         S_HOLD: begin
            // r_req_pc still names the skid word: no new request is issued from HOLD
            if (redirect) begin
               w_pc_q_next  = w_redirect_pc;
               w_valid_next = 1'b0;
               w_instr_next = NOP_INSTR;
               w_state_next = S_REQ;
            end else if (!stall) begin
               w_pc_out_next = r_req_pc;
               w_instr_next  = r_skid;
               w_valid_next  = 1'b1;
               w_state_next  = S_REQ;
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state         <= S_IDLE;
         r_pc_q          <= RESET_PC;
         r_req_pc        <= 32'd0;
         r_skid          <= NOP_INSTR;
         r_kill          <= 1'b0;
         pc_out          <= 32'd0;
         instruction_out <= NOP_INSTR;
         valid_out       <= 1'b0;
      end else begin
         r_state         <= w_state_next;
         r_pc_q          <= w_pc_q_next;
         r_req_pc        <= w_req_pc_next;
         r_skid          <= w_skid_next;
         r_kill          <= w_kill_next;
         pc_out          <= w_pc_out_next;
         instruction_out <= w_instr_next;
         valid_out       <= w_valid_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_inst_fetch_unit
// Directed bench with a memory responder and an in-order expected-word queue.
// Revision: 1.0
// ============================================================================
module tb_inst_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] pc_out;
   logic [31:0] instruction_out;
   logic        valid_out;

   inst_fetch_unit_if imem_bus ();

   inst_fetch_unit #(
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (NOP)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .stall           (stall),
      .redirect        (redirect),
      .redirect_pc     (redirect_pc),
      .imem            (imem_bus),
      .pc_out          (pc_out),
      .instruction_out (instruction_out),
      .valid_out       (valid_out)
   );

   always #5 clk = ~clk;

   int          tests = 0;
   int          fails = 0;
   logic [63:0] sb[$];
   int          lat = 1;
   int          cnt = 0;
   int          expect_drop = 0;
   bit          acc_last = 1'b0;
   logic [31:0] acc_addr = 32'd0;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return a ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!imem_bus.imem_req && n < 20) begin
         step();
         n++;
      end
      chk({tag, "_req"}, {31'd0, imem_bus.imem_req}, 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      do begin
         step();
         n++;
      end while (!valid_out && n < 20);
      chk({tag, "_valid"}, {31'd0, valid_out}, 32'd1);
   endtask

   // Everything not yet consumed is flushed; an in-flight response must be dropped.
   task automatic do_redirect(input logic [31:0] target);
      redirect    = 1'b1;
      redirect_pc = target;
      step();
      redirect = 1'b0;
      sb.delete();
      if (acc_last || cnt > 0) expect_drop = 1;
   endtask

   // Memory responder and consume-side scoreboard check
   always @(negedge clk) begin
      if (!reset) begin
         imem_bus.imem_rvalid = 1'b0;
         cnt      = 0;
         acc_last = 1'b0;
      end else begin
         if (valid_out && !stall) begin
            tests++;
            assert (sb.size() != 0) else begin
               fails++;
               $error("FAIL sb_underflow observed pc=%h instr=%h expected=none", pc_out, instruction_out);
            end
            if (sb.size() != 0) begin
               logic [63:0] e;
               e = sb.pop_front();
               chk("sb_pc", pc_out, e[63:32]);
               chk("sb_instr", instruction_out, e[31:0]);
            end
         end
         imem_bus.imem_rvalid = 1'b0;
         if (acc_last) cnt = lat;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               imem_bus.imem_rvalid = 1'b1;
               imem_bus.imem_rdata  = memfn(acc_addr);
               if (expect_drop > 0) expect_drop--;
               else sb.push_back({acc_addr, memfn(acc_addr)});
            end
         end
         acc_last = imem_bus.imem_req && imem_bus.imem_ready;
         if (acc_last) acc_addr = imem_bus.imem_addr;
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset                = 1'b0;
      stall                = 1'b0;
      redirect             = 1'b0;
      redirect_pc          = 32'd0;
      imem_bus.imem_ready  = 1'b1;
      imem_bus.imem_rvalid = 1'b0;
      imem_bus.imem_rdata  = 32'd0;
      step();
      step();
      chk("rst_valid", {31'd0, valid_out}, 32'd0);
      chk("rst_pc", pc_out, 32'd0);
      chk("rst_instr", instruction_out, NOP);
      chk("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);

      // Basic fetch of two words
      reset = 1'b1;
      step();
      chk("t1_req", {31'd0, imem_bus.imem_req}, 32'd1);
      chk("t1_addr0", imem_bus.imem_addr, 32'h0);
      wait_valid("t1a");
      chk("t1_pc0", pc_out, 32'h0);
      chk("t1_instr0", instruction_out, 32'h0050_0093);
      chk("t1_addr4", imem_bus.imem_addr, 32'h4);
      wait_valid("t1b");
      chk("t1_pc4", pc_out, 32'h4);
      chk("t1_instr4", instruction_out, 32'h0010_0113);

      // Stall while a response lands: HOLD, then skid word presented
      stall = 1'b1;
      step();
      chk("t2_wait_req", {31'd0, imem_bus.imem_req}, 32'd0);
      step();
      chk("t2_hold_valid", {31'd0, valid_out}, 32'd1);
      chk("t2_hold_pc", pc_out, 32'h4);
      chk("t2_hold_req", {31'd0, imem_bus.imem_req}, 32'd0);
      step();
      chk("t2_hold2_pc", pc_out, 32'h4);
      chk("t2_hold2_instr", instruction_out, 32'h0010_0113);
      stall = 1'b0;
      step();
      chk("t2_skid_valid", {31'd0, valid_out}, 32'd1);
      chk("t2_skid_pc", pc_out, 32'h8);
      chk("t2_skid_instr", instruction_out, memfn(32'h8));
      chk("t2_next_addr", imem_bus.imem_addr, 32'hC);

      // Redirect while waiting on a slow response
      lat = 3;
      step();
      chk("t3_wait", {31'd0, imem_bus.imem_req}, 32'd0);
      do_redirect(32'h0000_0100);
      chk("t3_flush_valid", {31'd0, valid_out}, 32'd0);
      chk("t3_flush_instr", instruction_out, NOP);
      lat = 1;
      step();
      chk("t3_gap_valid", {31'd0, valid_out}, 32'd0);
      wait_req("t3");
      chk("t3_gap2_valid", {31'd0, valid_out}, 32'd0);
      chk("t3_addr", imem_bus.imem_addr, 32'h100);
      wait_valid("t3");
      chk("t3_pc", pc_out, 32'h100);
      chk("t3_instr", instruction_out, memfn(32'h100));

      // Redirect overrides stall, low address bits cleared
      stall = 1'b1;
      do_redirect(32'h0000_0203);
      chk("t4_valid", {31'd0, valid_out}, 32'd0);
      chk("t4_instr", instruction_out, NOP);
      stall = 1'b0;
      wait_req("t4");
      chk("t4_addr", imem_bus.imem_addr, 32'h200);
      wait_valid("t4");
      chk("t4_pc", pc_out, 32'h200);

      // PC wrap at the top of the address space
      do_redirect(32'hFFFF_FFFC);
      wait_req("t5");
      chk("t5_addr_top", imem_bus.imem_addr, 32'hFFFF_FFFC);
      wait_valid("t5a");
      chk("t5_pc_top", pc_out, 32'hFFFF_FFFC);
      chk("t5_instr_top", instruction_out, memfn(32'hFFFF_FFFC));
      chk("t5_addr_wrap", imem_bus.imem_addr, 32'h0);
      wait_valid("t5b");
      chk("t5_pc_wrap", pc_out, 32'h0);
      chk("t5_instr_wrap", instruction_out, 32'h0050_0093);

      // Asynchronous reset while in WAIT
      wait_valid("t6a");
      chk("t6_pc4", pc_out, 32'h4);
      stall = 1'b1;
      lat   = 3;
      step();
      chk("t6_in_wait", {31'd0, imem_bus.imem_req}, 32'd0);
      #2;
      reset = 1'b0;
      sb.delete();
      expect_drop          = 0;
      cnt                  = 0;
      acc_last             = 1'b0;
      imem_bus.imem_rvalid = 1'b0;
      #1;
      chk("t6_async_valid", {31'd0, valid_out}, 32'd0);
      chk("t6_async_pc", pc_out, 32'd0);
      chk("t6_async_instr", instruction_out, NOP);
      chk("t6_async_req", {31'd0, imem_bus.imem_req}, 32'd0);
      stall = 1'b0;
      lat   = 1;
      step();
      step();
      reset = 1'b1;
      wait_req("t6");
      chk("t6_restart_addr", imem_bus.imem_addr, 32'h0);
      wait_valid("t6b");
      chk("t6_restart_pc", pc_out, 32'h0);
      chk("t6_restart_instr", instruction_out, 32'h0050_0093);
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
